// File: rtl/song_frame_loader.sv
// Framed UART song loader: parses HDR/len/notes frames into a note buffer and loops them to the player.
// Optional checksum byte at frame end is enabled by defining SONG_CHECKSUM_EN.
module song_frame_loader #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned TIMEOUT_MS = 500,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic       clk_1ms,
    input  logic       sys_rst_n,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ack_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic [7:0] out_index_o,
    output logic       song_valid_o,
    output logic [7:0] song_len_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_MS - 1);
    localparam logic [7:0]  DEPTH_B  = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef SONG_CHECKSUM_EN
        S_CSUM,
`endif
        S_COMMIT
    } state_t;

    state_t      state_q;
    logic        rx_ack_q;
    logic [15:0] tmo_q;
    logic [7:0]  len_q;
    logic [7:0]  wr_ptr_q;
    logic [7:0]  rd_ptr_q;
    logic [7:0]  song_len_q;
    logic        song_valid_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic [7:0]  out_index_q;
    logic        frame_ok_q;
    logic        frame_err_q;
    logic [1:0]  err_code_q;
`ifdef SONG_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic [7:0] mem_q [2**AW];

    logic rx_take;
    logic in_frame;
    logic tmo_hit;
    logic hdr_abort;

    // No byte is taken while committing so the commit cycle never races a new header.
    assign rx_take   = rx_valid_i && !rx_ack_q && (state_q != S_COMMIT);
    assign in_frame  = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef SONG_CHECKSUM_EN
                       || (state_q == S_CSUM)
`endif
                       ;
    assign tmo_hit   = in_frame && !rx_take && (tmo_q == TMO_LAST);
    assign hdr_abort = rx_take && (state_q == S_IDLE) && (rx_data_i == HDR_BYTE);

    always_ff @(posedge clk_1ms) begin
        if (rx_take && state_q == S_DATA) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_1ms or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            rx_ack_q     <= 1'b0;
            tmo_q        <= '0;
            len_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            song_len_q   <= '0;
            song_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
`ifdef SONG_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (rx_take) begin
                rx_ack_q <= 1'b1;
            end else if (!rx_valid_i) begin
                rx_ack_q <= 1'b0;
            end

            tmo_q <= (in_frame && !rx_take) ? tmo_q + 16'd1 : '0;

            if (tmo_hit) begin
                state_q     <= S_IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd3;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (hdr_abort) begin
                            state_q      <= S_LEN;
                            song_valid_q <= 1'b0;
                        end
                    end
                    S_LEN: begin
                        if (rx_take) begin
                            if (rx_data_i == 8'd0 || rx_data_i > DEPTH_B) begin
                                state_q     <= S_IDLE;
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'd1;
                            end else begin
                                len_q    <= rx_data_i;
                                wr_ptr_q <= '0;
                                state_q  <= S_DATA;
`ifdef SONG_CHECKSUM_EN
                                csum_q   <= rx_data_i;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_take) begin
                            wr_ptr_q <= wr_ptr_q + 8'd1;
`ifdef SONG_CHECKSUM_EN
                            csum_q   <= csum_q ^ rx_data_i;
                            if (wr_ptr_q == len_q - 8'd1) state_q <= S_CSUM;
`else
                            if (wr_ptr_q == len_q - 8'd1) state_q <= S_COMMIT;
`endif
                        end
                    end
`ifdef SONG_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_take) begin
                            if (rx_data_i == csum_q) begin
                                state_q <= S_COMMIT;
                            end else begin
                                state_q     <= S_IDLE;
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'd2;
                            end
                        end
                    end
`endif
                    S_COMMIT: begin
                        song_len_q   <= len_q;
                        song_valid_q <= 1'b1;
                        rd_ptr_q     <= '0;
                        frame_ok_q   <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end

            // Playback: fetch, present until accepted, then one idle cycle while the next fetch lands.
            if (hdr_abort) begin
                out_valid_q <= 1'b0;
            end else if (out_valid_q) begin
                if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    rd_ptr_q    <= (rd_ptr_q == song_len_q - 8'd1) ? 8'd0 : rd_ptr_q + 8'd1;
                end
            end else if (song_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
                out_index_q <= rd_ptr_q;
            end
        end
    end

    assign rx_ack_o     = rx_ack_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_index_o  = out_index_q;
    assign song_valid_o = song_valid_q;
    assign song_len_o   = song_len_q;
    assign frame_ok_o   = frame_ok_q;
    assign frame_err_o  = frame_err_q;
    assign err_code_o   = err_code_q;

endmodule
